// File: rtl/piso_serializer_if.sv
// Word-in / bit-out handshake bundle for the parallel-in serial-out stage.
// master drives words in and observes the serial side; slave is the serializer.
interface piso_serializer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             data_out;
    logic             bit_valid;
    logic             word_start;
    logic             word_done;
    logic             busy;

    modport master (
        output in_valid, in_data,
        input  in_ready, data_out, bit_valid, word_start, word_done, busy
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, data_out, bit_valid, word_start, word_done, busy
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage: accepts a WIDTH-bit word over valid/ready and
// emits it one bit per clock, with optional idle gap cycles between words.
module piso_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned GAP       = 0,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    piso_serializer_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [7:0]       GAP_LAST = 8'((GAP == 0) ? 0 : GAP - 1);
    localparam logic             GAP_EN   = (GAP != 0);
    localparam logic             MSB_EN   = (MSB_FIRST != 0);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]       gap_cnt_q, gap_cnt_d;

    logic ready_c;
    logic accept_c;
    logic live_c;
    logic out_bit_c;

    // Ready depends only on registered state so it never loops through in_valid.
    always_comb begin
        ready_c = 1'b0;
        case (state_q)
            S_IDLE:  ready_c = 1'b1;
            S_SHIFT: ready_c = (bit_cnt_q == LAST_BIT) && !GAP_EN;
            S_GAP:   ready_c = (gap_cnt_q == GAP_LAST);
            default: ready_c = 1'b0;
        endcase
    end

    assign accept_c  = bus.in_valid & ready_c;
    assign live_c    = (state_q == S_SHIFT);
    assign out_bit_c = MSB_EN ? shreg_q[WIDTH-1] : shreg_q[0];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    shreg_d   = bus.in_data;
                    bit_cnt_d = '0;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // Zero fill keeps the register empty once the word has drained.
                shreg_d   = MSB_EN ? {shreg_q[WIDTH-2:0], 1'b0}
                                   : {1'b0, shreg_q[WIDTH-1:1]};
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_d = '0;
                    if (accept_c) begin
                        shreg_d = bus.in_data;
                    end else if (GAP_EN) begin
                        gap_cnt_d = '0;
                        state_d   = S_GAP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                gap_cnt_d = gap_cnt_q + 8'd1;
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    if (accept_c) begin
                        shreg_d   = bus.in_data;
                        bit_cnt_d = '0;
                        state_d   = S_SHIFT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.in_ready   = ready_c;
    assign bus.bit_valid  = live_c;
    assign bus.data_out   = live_c & out_bit_c;
    assign bus.word_start = live_c & (bit_cnt_q == '0);
    assign bus.word_done  = live_c & (bit_cnt_q == LAST_BIT);
    assign bus.busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: three parameterisations plus a shift8
// model reassembling the MSB-first stream.
module tb_piso_serializer;
    logic clk;
    logic rst_n;
    int   passed;
    int   total;

    piso_serializer_if #(.WIDTH(8)) b0 ();
    piso_serializer_if #(.WIDTH(8)) bg ();
    piso_serializer_if #(.WIDTH(8)) bl ();

    piso_serializer #(.WIDTH(8), .GAP(0), .MSB_FIRST(1)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    piso_serializer #(.WIDTH(8), .GAP(2), .MSB_FIRST(1)) u_dutg (.clk(clk), .rst_n(rst_n), .bus(bg));
    piso_serializer #(.WIDTH(8), .GAP(0), .MSB_FIRST(0)) u_dutl (.clk(clk), .rst_n(rst_n), .bus(bl));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream shift8: samples data_out on every rising edge.
    logic [7:0] sh8;
    always_ff @(posedge clk) sh8 <= {sh8[6:0], b0.data_out};

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({b0.busy, b0.bit_valid, b0.data_out, b0.word_start, b0.word_done} !== 5'b0) begin
            $display("FAIL reset_hold: got %b want 00000",
                     {b0.busy, b0.bit_valid, b0.data_out, b0.word_start, b0.word_done});
        end else passed++;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({b0.in_ready, bg.in_ready, bl.in_ready} !== 3'b111) begin
            $display("FAIL reset_ready: got %b want 111", {b0.in_ready, bg.in_ready, bl.in_ready});
        end else passed++;
        total++;
        if ({b0.busy, bg.busy, bl.busy, b0.bit_valid, bg.bit_valid, bl.bit_valid} !== 6'b0) begin
            $display("FAIL reset_idle: got %b want 000000",
                     {b0.busy, bg.busy, bl.busy, b0.bit_valid, bg.bit_valid, bl.bit_valid});
        end else passed++;
    endtask

    task automatic test_single;
        logic [7:0] w;
        logic [4:0] exp_v;
        w = 8'b01110101;
        b0.in_valid = 1'b1;
        b0.in_data  = w;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            b0.in_valid = 1'b0;
            exp_v = {1'b1, w[7-i], (i == 0), (i == 7), 1'b1};
            total++;
            if ({b0.bit_valid, b0.data_out, b0.word_start, b0.word_done, b0.busy} !== exp_v) begin
                $display("FAIL single_bit%0d: got %b want %b", i,
                         {b0.bit_valid, b0.data_out, b0.word_start, b0.word_done, b0.busy}, exp_v);
            end else passed++;
        end
        @(negedge clk);
        total++;
        if ({b0.busy, b0.bit_valid, b0.data_out, b0.in_ready} !== 4'b0001) begin
            $display("FAIL single_after: got %b want 0001",
                     {b0.busy, b0.bit_valid, b0.data_out, b0.in_ready});
        end else passed++;
        total++;
        if (sh8 !== w) begin
            $display("FAIL single_shift8: got %h want %h", sh8, w);
        end else passed++;
    endtask

    task automatic test_back_to_back;
        logic [15:0] s;
        logic [3:0]  exp_v;
        s = 16'hA53C;
        b0.in_valid = 1'b1;
        b0.in_data  = 8'hA5;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            exp_v = {1'b1, s[15-i], (i == 7 || i == 15), (i == 0 || i == 8)};
            total++;
            if ({b0.bit_valid, b0.data_out, b0.in_ready, b0.word_start} !== exp_v) begin
                $display("FAIL b2b_bit%0d: got %b want %b", i,
                         {b0.bit_valid, b0.data_out, b0.in_ready, b0.word_start}, exp_v);
            end else passed++;
            if (i == 0) b0.in_data = 8'h3C;
            if (i == 8) b0.in_valid = 1'b0;
        end
        @(negedge clk);
        total++;
        if ({b0.bit_valid, b0.busy, b0.in_ready, sh8} !== {3'b001, 8'h3C}) begin
            $display("FAIL b2b_after: got %b want %b",
                     {b0.bit_valid, b0.busy, b0.in_ready, sh8}, {3'b001, 8'h3C});
        end else passed++;
    endtask

    task automatic test_gap;
        logic [2:0] exp_v;
        logic       live;
        bg.in_valid = 1'b1;
        bg.in_data  = 8'hFF;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            live  = (i < 8) || (i >= 10 && i < 18);
            exp_v = {live, (i < 8), (i == 9 || i == 19)};
            total++;
            if ({bg.bit_valid, bg.data_out, bg.in_ready} !== exp_v) begin
                $display("FAIL gap_cyc%0d: got %b want %b", i,
                         {bg.bit_valid, bg.data_out, bg.in_ready}, exp_v);
            end else passed++;
            if (i == 0)  bg.in_data  = 8'h00;
            if (i == 10) bg.in_valid = 1'b0;
        end
        @(negedge clk);
        total++;
        if ({bg.busy, bg.in_ready} !== 2'b01) begin
            $display("FAIL gap_idle: got %b want 01", {bg.busy, bg.in_ready});
        end else passed++;
    endtask

    task automatic test_lsb_first;
        logic [7:0] words [2];
        logic [3:0] exp_v;
        words[0] = 8'h01;
        words[1] = 8'hB2;
        for (int k = 0; k < 2; k++) begin
            bl.in_valid = 1'b1;
            bl.in_data  = words[k];
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                bl.in_valid = 1'b0;
                exp_v = {1'b1, words[k][i], (i == 0), (i == 7)};
                total++;
                if ({bl.bit_valid, bl.data_out, bl.word_start, bl.word_done} !== exp_v) begin
                    $display("FAIL lsb_w%0d_bit%0d: got %b want %b", k, i,
                             {bl.bit_valid, bl.data_out, bl.word_start, bl.word_done}, exp_v);
                end else passed++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] w;
        logic [7:0] a;
        a = 8'hC3;
        b0.in_valid = 1'b1;
        b0.in_data  = a;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            b0.in_valid = 1'b0;
            total++;
            if ({b0.bit_valid, b0.data_out} !== {1'b1, a[7-i]}) begin
                $display("FAIL rstmid_bit%0d: got %b want %b", i,
                         {b0.bit_valid, b0.data_out}, {1'b1, a[7-i]});
            end else passed++;
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({b0.bit_valid, b0.data_out, b0.busy} !== 3'b000) begin
            $display("FAIL rstmid_async: got %b want 000", {b0.bit_valid, b0.data_out, b0.busy});
        end else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        total++;
        if ({b0.in_ready, b0.busy} !== 2'b10) begin
            $display("FAIL rstmid_release: got %b want 10", {b0.in_ready, b0.busy});
        end else passed++;
        w = 8'h5A;
        b0.in_valid = 1'b1;
        b0.in_data  = w;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            b0.in_valid = 1'b0;
            total++;
            if ({b0.bit_valid, b0.data_out, b0.word_start} !== {1'b1, w[7-i], (i == 0)}) begin
                $display("FAIL rstmid_next_bit%0d: got %b want %b", i,
                         {b0.bit_valid, b0.data_out, b0.word_start}, {1'b1, w[7-i], (i == 0)});
            end else passed++;
        end
        @(negedge clk);
        total++;
        if (sh8 !== w) begin
            $display("FAIL rstmid_shift8: got %h want %h", sh8, w);
        end else passed++;
    endtask

    task automatic test_stall;
        logic [7:0] w0;
        logic [7:0] w1;
        logic [7:0] cur;
        w0 = 8'h96;
        w1 = 8'h4D;
        b0.in_valid = 1'b1;
        b0.in_data  = w0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            cur = (i < 8) ? w0 : w1;
            total++;
            if ({b0.bit_valid, b0.data_out} !== {1'b1, cur[7 - (i % 8)]}) begin
                $display("FAIL stall_bit%0d: got %b want %b", i,
                         {b0.bit_valid, b0.data_out}, {1'b1, cur[7 - (i % 8)]});
            end else passed++;
            if (i < 7)       b0.in_data = 8'(i * 37 + 11);
            else if (i == 7) b0.in_data = w1;
            else begin
                b0.in_valid = 1'b0;
                b0.in_data  = 8'(i * 53);
            end
        end
        @(negedge clk);
        total++;
        if ({b0.busy, sh8} !== {1'b0, w1}) begin
            $display("FAIL stall_shift8: got %b want %b", {b0.busy, sh8}, {1'b0, w1});
        end else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst_n  = 1'b0;
        b0.in_valid = 1'b0; b0.in_data = '0;
        bg.in_valid = 1'b0; bg.in_data = '0;
        bl.in_valid = 1'b0; bl.in_data = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_gap();
        test_lsb_first();
        test_reset_mid();
        test_stall();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
